up_input_sequencer: RTL and testbench

- Host-side feeder for the microprocessor's operand entry port: buffers bytes queued by a host or script engine, then presents them one at a time on the uP's Input bus with an Enter strobe.
- Waits for the uP's input-latch acknowledge before releasing each byte, and pauses while the uP is halted.
- Sits between the bench/host and the uP Input/Enter pins, in place of hand-driven stimulus.

---
 rtl/up_input_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_up_input_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/up_input_sequencer.sv
// up_input_sequencer: FIFO-buffered byte feeder driving the uP Input/Enter entry port.
// Define UP_INPUT_SEQ_TIMEOUT_EN to build the acknowledge-wait timeout and timeout_err flag.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   IDLE     | waiting for a queued byte and Halt low; pops into hold
//   SETUP    | held byte on Input, Enter low (data setup)
//   STROBE   | Enter high for ENTER_CYCLES cycles
//   WAIT_ACK | Enter low, waiting for the InLoad acknowledge
//   GAP      | idle spacing of GAP_CYCLES cycles before the next byte
module up_input_sequencer #(
  parameter int DEPTH          = 8,
  parameter int ENTER_CYCLES   = 2,
  parameter int GAP_CYCLES     = 3,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       push,
  input  logic [7:0] push_data,
  output logic       full,
  output logic       empty,
  output logic       overflow,
  input  logic       clr_err,
  input  logic       Halt,
  input  logic       InLoad,
  output logic [7:0] Input,
  output logic       Enter,
  output logic       busy,
  output logic [7:0] sent_count,
  output logic       timeout_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of two and at least 2");
  end
  if (ENTER_CYCLES < 1 || ENTER_CYCLES > 15 || GAP_CYCLES < 0 || GAP_CYCLES > 15
      || TIMEOUT_CYCLES < 1) begin : g_bad_timing
    $error("timing parameter out of range");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_STROBE, S_WAIT_ACK, S_GAP
  } state_t;

  state_t          state, state_nxt;
  logic [3:0]      tmr, tmr_nxt;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic [7:0]      hold;
  logic            pop, push_ok, ack;

`ifdef UP_INPUT_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0]   to_cnt;
  logic            to_err;
  logic            tmo;
`endif

  assign full       = (count == CW'(DEPTH));
  assign empty      = (count == '0);
  assign push_ok    = push && (!full || pop);
  assign Input      = hold;
  assign Enter      = (state == S_STROBE);
  assign busy       = (state != S_IDLE);

  always_comb begin
    state_nxt = state;
    tmr_nxt   = tmr;
    pop       = 1'b0;
    ack       = 1'b0;
`ifdef UP_INPUT_SEQ_TIMEOUT_EN
    tmo       = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (!empty && !Halt) begin
          pop       = 1'b1;
          state_nxt = S_SETUP;
        end
      end
      S_SETUP: begin
        state_nxt = S_STROBE;
        tmr_nxt   = 4'(ENTER_CYCLES - 1);
      end
      S_STROBE: begin
        // an acknowledge during the strobe ends it early and skips WAIT_ACK
        if (InLoad) begin
          ack = 1'b1;
        end else if (tmr == '0) begin
          state_nxt = S_WAIT_ACK;
        end else begin
          tmr_nxt = tmr - 1'b1;
        end
      end
      S_WAIT_ACK: begin
        if (InLoad) begin
          ack = 1'b1;
        end
`ifdef UP_INPUT_SEQ_TIMEOUT_EN
        else if (to_cnt == '0) begin
          tmo = 1'b1;
        end
`endif
      end
      S_GAP: begin
        if (tmr == '0) begin
          state_nxt = S_IDLE;
        end else begin
          tmr_nxt = tmr - 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    if (ack
`ifdef UP_INPUT_SEQ_TIMEOUT_EN
        || tmo
`endif
       ) begin
      tmr_nxt = 4'(GAP_CYCLES - 1);
      if (GAP_CYCLES == 0) begin
        state_nxt = S_IDLE;
      end else begin
        state_nxt = S_GAP;
      end
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state      <= S_IDLE;
      tmr        <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      hold       <= '0;
      sent_count <= '0;
      overflow   <= 1'b0;
    end else begin
      state <= state_nxt;
      tmr   <= tmr_nxt;
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        hold   <= mem[rd_ptr];
      end
      if (push_ok && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push_ok) begin
        count <= count - 1'b1;
      end
      if (ack) begin
        sent_count <= sent_count + 1'b1;
      end
      if (push && !push_ok) begin
        overflow <= 1'b1;
      end else if (clr_err) begin
        overflow <= 1'b0;
      end
    end
  end

  // storage needs no reset; count and pointers define validity
  always_ff @(posedge CLOCK) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

`ifdef UP_INPUT_SEQ_TIMEOUT_EN
  // down-counter reloads outside WAIT_ACK, so it reads TIMEOUT_CYCLES-1 on entry
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      to_cnt <= '0;
      to_err <= 1'b0;
    end else begin
      if (state != S_WAIT_ACK) begin
        to_cnt <= TW'(TIMEOUT_CYCLES - 1);
      end else if (to_cnt != '0) begin
        to_cnt <= to_cnt - 1'b1;
      end
      if (tmo) begin
        to_err <= 1'b1;
      end else if (clr_err) begin
        to_err <= 1'b0;
      end
    end
  end
  assign timeout_err = to_err;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_up_input_sequencer.sv
// Bench for up_input_sequencer: directed timeline checks plus randomized bursts
// scored against a byte-order / acknowledge-count model.
module tb_up_input_sequencer;
  localparam int DEPTH = 8;

  logic       CLOCK = 1'b0;
  logic       RESET = 1'b1;
  logic       push = 1'b0;
  logic [7:0] push_data = 8'h00;
  logic       clr_err = 1'b0;
  logic       Halt = 1'b0;
  logic       InLoad = 1'b0;
  logic       full, empty, overflow, Enter, busy, timeout_err;
  logic [7:0] Input, sent_count;

  int total = 0;
  int bad = 0;
  bit auto_ack = 1'b0;
  bit enter_prev = 1'b0;
  int ack_cd = -1;
  logic [7:0] seen_q[$];
  logic [7:0] exp_q[$];

  up_input_sequencer dut (
    .CLOCK(CLOCK), .RESET(RESET), .push(push), .push_data(push_data),
    .full(full), .empty(empty), .overflow(overflow), .clr_err(clr_err),
    .Halt(Halt), .InLoad(InLoad), .Input(Input), .Enter(Enter), .busy(busy),
    .sent_count(sent_count), .timeout_err(timeout_err)
  );

  always #5 CLOCK = ~CLOCK;

  // one cycle: land on the falling edge, run the ack responder, record bytes strobed in
  task automatic tick();
    @(negedge CLOCK);
    if (auto_ack) begin
      InLoad = 1'b0;
      if (Enter && !enter_prev) ack_cd = $urandom_range(0, 5);
      if (ack_cd == 0) begin
        InLoad = 1'b1;
        ack_cd = -1;
      end else if (ack_cd > 0) begin
        ack_cd--;
      end
    end
    if (Enter && !enter_prev) seen_q.push_back(Input);
    enter_prev = Enter;
  endtask

  task automatic do_reset();
    auto_ack = 1'b0;
    push = 1'b0; InLoad = 1'b0; Halt = 1'b0; clr_err = 1'b0;
    RESET = 1'b1;
    tick(); tick();
    RESET = 1'b0;
    tick();
    seen_q.delete(); exp_q.delete();
    ack_cd = -1;
  endtask

  task automatic start_auto();
    auto_ack = 1'b1;
    ack_cd = -1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    push = 1'b1; push_data = b;
    tick();
    push = 1'b0;
  endtask

  task automatic wait_enter(input int limit);
    int n = 0;
    while (!Enter && n < limit) begin tick(); n++; end
    total++;
    if (Enter !== 1'b1) begin $display("FAIL wait_enter got=%0b want=1", Enter); bad++; end
  endtask

  task automatic drain(input int limit);
    int n = 0;
    while ((busy || !empty) && n < limit) begin tick(); n++; end
    total++;
    if (busy !== 1'b0 || empty !== 1'b1) begin
      $display("FAIL drain busy=%0b empty=%0b want busy=0 empty=1", busy, empty); bad++;
    end
  endtask

  task automatic test_reset();
    int n = 0;
    do_reset();
    total++; if (Input !== 8'h00)   begin $display("FAIL rst_input got=%h want=00", Input); bad++; end
    total++; if (Enter !== 1'b0)    begin $display("FAIL rst_enter got=%0b want=0", Enter); bad++; end
    total++; if (empty !== 1'b1)    begin $display("FAIL rst_empty got=%0b want=1", empty); bad++; end
    total++; if (full !== 1'b0)     begin $display("FAIL rst_full got=%0b want=0", full); bad++; end
    total++; if (busy !== 1'b0)     begin $display("FAIL rst_busy got=%0b want=0", busy); bad++; end
    total++; if (sent_count !== 8'd0) begin $display("FAIL rst_sent got=%0d want=0", sent_count); bad++; end
    total++; if (overflow !== 1'b0) begin $display("FAIL rst_ovf got=%0b want=0", overflow); bad++; end
    total++; if (timeout_err !== 1'b0) begin $display("FAIL rst_tmo got=%0b want=0", timeout_err); bad++; end
    // reset in the middle of a strobe drops everything
    push_byte(8'hAA);
    push_byte(8'hBB);
    wait_enter(20);
    RESET = 1'b1;
    tick();
    total++; if (Enter !== 1'b0) begin $display("FAIL midrst_enter got=%0b want=0", Enter); bad++; end
    total++; if (Input !== 8'h00) begin $display("FAIL midrst_input got=%h want=00", Input); bad++; end
    total++; if (empty !== 1'b1 || busy !== 1'b0) begin
      $display("FAIL midrst_state empty=%0b busy=%0b want 1/0", empty, busy); bad++;
    end
    RESET = 1'b0;
    while (n < 10) begin tick(); n++; end
    total++; if (busy !== 1'b0) begin $display("FAIL midrst_idle busy=%0b want=0", busy); bad++; end
  endtask

  task automatic test_single();
    logic [7:0] e_in;
    logic e_en, e_busy;
    logic [7:0] e_sent;
    do_reset();
    for (int k = 0; k <= 10; k++) begin
      e_in   = (k >= 2) ? 8'hA5 : 8'h00;
      e_en   = (k == 3 || k == 4);
      e_busy = (k >= 2 && k <= 8);
      e_sent = (k >= 6) ? 8'd1 : 8'd0;
      total++; if (Input !== e_in) begin $display("FAIL single_input k=%0d got=%h want=%h", k, Input, e_in); bad++; end
      total++; if (Enter !== e_en) begin $display("FAIL single_enter k=%0d got=%0b want=%0b", k, Enter, e_en); bad++; end
      total++; if (busy !== e_busy) begin $display("FAIL single_busy k=%0d got=%0b want=%0b", k, busy, e_busy); bad++; end
      total++; if (sent_count !== e_sent) begin $display("FAIL single_sent k=%0d got=%0d want=%0d", k, sent_count, e_sent); bad++; end
      push = (k == 0);
      push_data = 8'hA5;
      InLoad = (k == 5);
      tick();
    end
    push = 1'b0; InLoad = 1'b0;
  endtask

  task automatic test_burst_full();
    do_reset();
    Halt = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      push = 1'b1; push_data = 8'(i);
      tick();
      if (i == 7) begin
        total++; if (full !== 1'b0) begin $display("FAIL burst_full7 got=%0b want=0", full); bad++; end
      end
      if (i == 8) begin
        total++; if (full !== 1'b1) begin $display("FAIL burst_full8 got=%0b want=1", full); bad++; end
        total++; if (overflow !== 1'b0) begin $display("FAIL burst_ovf8 got=%0b want=0", overflow); bad++; end
      end
      if (i == 9) begin
        total++; if (overflow !== 1'b1) begin $display("FAIL burst_ovf9 got=%0b want=1", overflow); bad++; end
      end
    end
    push = 1'b0;
    for (int i = 1; i <= DEPTH; i++) exp_q.push_back(8'(i));
    Halt = 1'b0;
    start_auto();
    drain(400);
    auto_ack = 1'b0; InLoad = 1'b0;
    total++; if (seen_q.size() != exp_q.size()) begin
      $display("FAIL burst_count got=%0d want=%0d", seen_q.size(), exp_q.size()); bad++;
    end
    for (int i = 0; i < exp_q.size() && i < seen_q.size(); i++) begin
      total++; if (seen_q[i] !== exp_q[i]) begin $display("FAIL burst_byte%0d got=%h want=%h", i, seen_q[i], exp_q[i]); bad++; end
    end
    total++; if (sent_count !== 8'd8) begin $display("FAIL burst_sent got=%0d want=8", sent_count); bad++; end
    total++; if (overflow !== 1'b1) begin $display("FAIL burst_ovf_sticky got=%0b want=1", overflow); bad++; end
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    total++; if (overflow !== 1'b0) begin $display("FAIL burst_clr got=%0b want=0", overflow); bad++; end
  endtask

  task automatic test_early_ack();
    do_reset();
    push_byte(8'h5A);
    wait_enter(20);
    total++; if (sent_count !== 8'd0) begin $display("FAIL early_pre got=%0d want=0", sent_count); bad++; end
    InLoad = 1'b1; tick(); InLoad = 1'b0;
    total++; if (Enter !== 1'b0) begin $display("FAIL early_enter got=%0b want=0", Enter); bad++; end
    total++; if (sent_count !== 8'd1) begin $display("FAIL early_sent got=%0d want=1", sent_count); bad++; end
    total++; if (Input !== 8'h5A) begin $display("FAIL early_input got=%h want=5a", Input); bad++; end
    tick(); tick();
    total++; if (busy !== 1'b1) begin $display("FAIL early_gap got=%0b want=1", busy); bad++; end
    tick();
    total++; if (busy !== 1'b0) begin $display("FAIL early_idle got=%0b want=0", busy); bad++; end
  endtask

  task automatic test_halt();
    int n = 0;
    bit rose = 1'b0;
    do_reset();
    push_byte(8'h11);
    push_byte(8'h22);
    wait_enter(20);
    Halt = 1'b1;
    while (Enter && n < 20) begin tick(); n++; end
    InLoad = 1'b1; tick(); InLoad = 1'b0;
    total++; if (sent_count !== 8'd1) begin $display("FAIL halt_sent1 got=%0d want=1", sent_count); bad++; end
    for (int i = 0; i < 20; i++) begin tick(); if (Enter) rose = 1'b1; end
    total++; if (rose !== 1'b0) begin $display("FAIL halt_blocked got=%0b want=0", rose); bad++; end
    total++; if (busy !== 1'b0 || empty !== 1'b0) begin
      $display("FAIL halt_parked busy=%0b empty=%0b want 0/0", busy, empty); bad++;
    end
    total++; if (Input !== 8'h11) begin $display("FAIL halt_input got=%h want=11", Input); bad++; end
    Halt = 1'b0;
    start_auto();
    drain(100);
    auto_ack = 1'b0; InLoad = 1'b0;
    total++; if (seen_q.size() != 2) begin $display("FAIL halt_count got=%0d want=2", seen_q.size()); bad++; end
    else begin
      total++; if (seen_q[0] !== 8'h11 || seen_q[1] !== 8'h22) begin
        $display("FAIL halt_order got=%h,%h want=11,22", seen_q[0], seen_q[1]); bad++;
      end
    end
    total++; if (sent_count !== 8'd2) begin $display("FAIL halt_sent2 got=%0d want=2", sent_count); bad++; end
  endtask

  task automatic test_random();
    int model_sent = 0;
    int n;
    logic [7:0] b;
    do_reset();
    for (int r = 0; r < 12; r++) begin
      seen_q.delete(); exp_q.delete();
      start_auto();
      n = $urandom_range(1, DEPTH);
      for (int j = 0; j < n; j++) begin
        for (int g = $urandom_range(0, 3); g > 0; g--) begin
          Halt = ($urandom_range(0, 3) == 0);
          tick();
        end
        Halt = ($urandom_range(0, 3) == 0);
        b = 8'($urandom);
        exp_q.push_back(b);
        push_byte(b);
      end
      Halt = 1'b0;
      drain(400);
      model_sent += n;
      total++; if (seen_q.size() != exp_q.size()) begin
        $display("FAIL rand%0d_count got=%0d want=%0d", r, seen_q.size(), exp_q.size()); bad++;
      end
      for (int i = 0; i < exp_q.size() && i < seen_q.size(); i++) begin
        total++; if (seen_q[i] !== exp_q[i]) begin
          $display("FAIL rand%0d_byte%0d got=%h want=%h", r, i, seen_q[i], exp_q[i]); bad++;
        end
      end
      total++; if (sent_count !== 8'(model_sent)) begin
        $display("FAIL rand%0d_sent got=%0d want=%0d", r, sent_count, 8'(model_sent)); bad++;
      end
      total++; if (overflow !== 1'b0) begin $display("FAIL rand%0d_ovf got=%0b want=0", r, overflow); bad++; end
    end
    auto_ack = 1'b0; InLoad = 1'b0;
  endtask

  task automatic test_timeout();
    int n = 0;
    do_reset();
    push_byte(8'h3C);
    wait_enter(20);
`ifdef UP_INPUT_SEQ_TIMEOUT_EN
    while (Enter && n < 20) begin tick(); n++; end
    for (int i = 0; i < 63; i++) tick();
    total++; if (timeout_err !== 1'b0) begin $display("FAIL tmo_early got=%0b want=0", timeout_err); bad++; end
    tick();
    total++; if (timeout_err !== 1'b1) begin $display("FAIL tmo_set got=%0b want=1", timeout_err); bad++; end
    total++; if (sent_count !== 8'd0) begin $display("FAIL tmo_sent got=%0d want=0", sent_count); bad++; end
    seen_q.delete();
    push_byte(8'h5A);
    start_auto();
    drain(100);
    auto_ack = 1'b0; InLoad = 1'b0;
    total++; if (seen_q.size() != 1) begin $display("FAIL tmo_next_count got=%0d want=1", seen_q.size()); bad++; end
    else begin
      total++; if (seen_q[0] !== 8'h5A) begin $display("FAIL tmo_next_byte got=%h want=5a", seen_q[0]); bad++; end
    end
    total++; if (sent_count !== 8'd1) begin $display("FAIL tmo_next_sent got=%0d want=1", sent_count); bad++; end
    total++; if (timeout_err !== 1'b1) begin $display("FAIL tmo_sticky got=%0b want=1", timeout_err); bad++; end
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    total++; if (timeout_err !== 1'b0) begin $display("FAIL tmo_clr got=%0b want=0", timeout_err); bad++; end
`else
    while (n < 200) begin tick(); n++; end
    total++; if (busy !== 1'b1) begin $display("FAIL noto_busy got=%0b want=1", busy); bad++; end
    total++; if (Enter !== 1'b0) begin $display("FAIL noto_enter got=%0b want=0", Enter); bad++; end
    total++; if (sent_count !== 8'd0) begin $display("FAIL noto_sent got=%0d want=0", sent_count); bad++; end
    total++; if (timeout_err !== 1'b0) begin $display("FAIL noto_flag got=%0b want=0", timeout_err); bad++; end
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst_full();
    test_early_ack();
    test_halt();
    test_random();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
